// File: rtl/mux_4x1_sync.sv
// ============================================================================
// Module   : mux_4x1_sync
// Brief    : 4:1 lane mux with a combinational result and an enable-gated
//            registered copy that also tracks the select and a change flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4x1_sync #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [4*WIDTH-1:0] in,
    input  logic [1:0]         sel,
    output logic [WIDTH-1:0]   y,
    output logic [3:0]         sel_onehot,
    output logic [WIDTH-1:0]   y_q,
    output logic [1:0]         sel_q,
    output logic               changed
);

    localparam logic [3:0] c_ONEHOT_BASE = 4'b0001;

    logic [WIDTH-1:0] w_lane [4];
    logic [WIDTH-1:0] w_y;
    logic             w_diff;

    logic [WIDTH-1:0] r_y_q;
    logic [1:0]       r_sel_q;
    logic             r_changed;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign w_lane[k] = in[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Result path is purely combinational, independent of clock, reset and enable.
    assign w_y        = w_lane[sel];
    assign w_diff     = (w_y != r_y_q);
    assign y          = w_y;
    assign sel_onehot = c_ONEHOT_BASE << sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q     <= '0;
            r_sel_q   <= 2'b00;
            r_changed <= 1'b0;
        end else if (en) begin
            r_y_q     <= w_y;
            r_sel_q   <= sel;
            r_changed <= w_diff;
        end else begin
            r_changed <= 1'b0;
        end
    end

    assign y_q     = r_y_q;
    assign sel_q   = r_sel_q;
    assign changed = r_changed;

endmodule

`default_nettype wire

// File: tb/tb_mux_4x1_sync.sv
// ============================================================================
// Module   : tb_mux_4x1_sync
// Brief    : Self-checking bench for mux_4x1_sync at WIDTH=1 and WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_4x1_sync;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  sel;
    logic [3:0]  in1;
    logic [31:0] in8;

    logic        y1, yq1, ch1;
    logic [7:0]  y8, yq8;
    logic [3:0]  oh1, oh8;
    logic [1:0]  sq1, sq8;
    logic        ch8;

    int checks = 0;
    int errors = 0;

    // Reference state: what each registered output should currently hold.
    logic [7:0] m_yq1, m_yq8;
    logic [1:0] m_sq;
    logic       m_ch1, m_ch8;

    mux_4x1_sync #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in1), .sel(sel),
        .y(y1), .sel_onehot(oh1), .y_q(yq1), .sel_q(sq1), .changed(ch1)
    );

    mux_4x1_sync #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(in8), .sel(sel),
        .y(y8), .sel_onehot(oh8), .y_q(yq8), .sel_q(sq8), .changed(ch8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lane(input logic [31:0] v, input int s, input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return 8'((v >> (s * w)) & mask);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input logic [1:0] s, input logic [3:0] a, input logic [31:0] b);
        chk("y_w1", {31'd0, y1}, {24'd0, lane({28'd0, a}, int'(s), 1)});
        chk("y_w8", {24'd0, y8}, {24'd0, lane(b, int'(s), 8)});
        chk("onehot_w1", {28'd0, oh1}, 32'd1 << s);
        chk("onehot_w8", {28'd0, oh8}, 32'd1 << s);
    endtask

    task automatic chk_regs();
        chk("yq_w1", {31'd0, yq1}, {24'd0, m_yq1});
        chk("yq_w8", {24'd0, yq8}, {24'd0, m_yq8});
        chk("selq_w1", {30'd0, sq1}, {30'd0, m_sq});
        chk("selq_w8", {30'd0, sq8}, {30'd0, m_sq});
        chk("changed_w1", {31'd0, ch1}, {31'd0, m_ch1});
        chk("changed_w8", {31'd0, ch8}, {31'd0, m_ch8});
    endtask

    task automatic model_reset();
        m_yq1 = '0; m_yq8 = '0; m_sq = 2'b00; m_ch1 = 1'b0; m_ch8 = 1'b0;
    endtask

    // One clock: drive at the falling edge, check comb, then registered after the rise.
    task automatic cycle(input logic e, input logic [1:0] s, input logic [3:0] a,
                         input logic [31:0] b);
        logic [7:0] ey1, ey8;
        @(negedge clk);
        en = e; sel = s; in1 = a; in8 = b;
        #1;
        chk_comb(s, a, b);
        ey1 = lane({28'd0, a}, int'(s), 1);
        ey8 = lane(b, int'(s), 8);
        @(posedge clk);
        if (rst_n) begin
            if (e) begin
                m_ch1 = (ey1 != m_yq1);
                m_ch8 = (ey8 != m_yq8);
                m_yq1 = ey1;
                m_yq8 = ey8;
                m_sq  = s;
            end else begin
                m_ch1 = 1'b0;
                m_ch8 = 1'b0;
            end
        end
        #1;
        chk_regs();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sel = 2'b00; in1 = 4'b0000; in8 = 32'h0;
        model_reset();
        #2;
        chk_regs();
        chk_comb(2'b00, 4'b0000, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle select, then a WIDTH=1 sweep with the wide lanes in parallel.
        cycle(1'b0, 2'b00, 4'b0000, 32'h0);
        for (int s = 0; s < 4; s++)
            cycle(1'b1, 2'(s), 4'b0111, 32'hD4C3B2A1);

        // Hold with enable low: comb output moves, registers do not.
        cycle(1'b0, 2'b00, 4'b0111, 32'hD4C3B2A1);
        cycle(1'b0, 2'b10, 4'b0111, 32'hD4C3B2A1);

        // Async reset between edges, with y still following the inputs.
        cycle(1'b1, 2'b01, 4'b0111, 32'hD4C3B2A1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_regs();
        sel = 2'b11;
        #1;
        chk_comb(2'b11, 4'b0111, 32'hD4C3B2A1);
        rst_n = 1'b1;
        cycle(1'b1, 2'b01, 4'b0111, 32'hD4C3B2A1);

        // Back-to-back differing captures keep changed high.
        cycle(1'b1, 2'b11, 4'b0111, 32'hD4C3B2A1);
        cycle(1'b1, 2'b00, 4'b0111, 32'hD4C3B2A1);

        // Randomized traffic, with an occasional asynchronous reset pulse.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_regs();
                rst_n = 1'b1;
            end
            cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  4'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
